// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and constants for the radix-2 DIT FFT sequencer slice.
//   fft_state_e : sequencer FSM encoding (IDLE, RUN, DRAIN, DONE)
//   WORD_SZ     : width of one complex sample word in the sample RAM
//   WORD_MID    : split point of the word; real part above, imaginary below
//   cplx_t      : packed view of a sample word, two's complement halves
// ---------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_e;

    localparam int WORD_SZ  = 32;
    localparam int WORD_MID = 16;

    // Real part in [31:16], imaginary part in [15:0].
    typedef struct packed {
        logic signed [WORD_SZ-WORD_MID-1:0] re;
        logic signed [WORD_MID-1:0]         im;
    } cplx_t;

    function automatic cplx_t make_cplx(input logic signed [15:0] re,
                                        input logic signed [15:0] im);
        cplx_t w;
        w.re = re;
        w.im = im;
        return w;
    endfunction

endpackage

// File: rtl/fft_controller_if.sv
// ---------------------------------------------------------------------------
// fft_controller_if
// Control bus between the FFT sequencer and the RAM / butterfly datapath.
//   i_start                    : start request, only honoured while idle
//   o_busy, o_done             : run status; o_done is a one-cycle pulse
//   o_rd_en, o_rd_addr_a/b     : operand read strobe and sample addresses
//   o_tw_addr                  : twiddle ROM index k, W = exp(-j*2*pi*k/N)
//   o_wr_en, o_wr_addr_a/b     : write-back strobe and addresses
//   o_state                    : current sequencer state for observation
// Handshake: there is no back-pressure. i_start is a level sampled on the
// rising clock edge while the sequencer is idle; every o_rd_en cycle is one
// butterfly read and every o_wr_en cycle is one butterfly write, both
// unconditionally accepted by the datapath.
// Modports: master = sequencer side, slave = datapath / requester side.
// ---------------------------------------------------------------------------
interface fft_controller_if #(
    parameter int LOG2N = 4
);
    import fft_pkg::*;

    logic               i_start;
    logic               o_busy;
    logic               o_done;
    logic               o_rd_en;
    logic [LOG2N-1:0]   o_rd_addr_a;
    logic [LOG2N-1:0]   o_rd_addr_b;
    logic [LOG2N-2:0]   o_tw_addr;
    logic               o_wr_en;
    logic [LOG2N-1:0]   o_wr_addr_a;
    logic [LOG2N-1:0]   o_wr_addr_b;
    fft_state_e         o_state;

    modport master (
        input  i_start,
        output o_busy, o_done,
        output o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
        output o_wr_en, o_wr_addr_a, o_wr_addr_b,
        output o_state
    );

    modport slave (
        output i_start,
        input  o_busy, o_done,
        input  o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
        input  o_wr_en, o_wr_addr_a, o_wr_addr_b,
        input  o_state
    );

endinterface

// File: rtl/fft_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_addr_gen
// Combinational address generator for one radix-2 DIT butterfly.
//   s       : stage index, 0 .. LOG2N-1
//   j       : butterfly index within the stage, 0 .. N/2-1
//   addr_a  : j with a zero inserted at bit s
//   addr_b  : addr_a with bit s set (partner sample, distance 2^s)
//   tw_addr : (j mod 2^s) << (LOG2N-1-s), truncated to LOG2N-1 bits
// ---------------------------------------------------------------------------
module fft_addr_gen #(
    parameter int LOG2N = 4,
    parameter int SW    = 2
) (
    input  logic [SW-1:0]    s,
    input  logic [LOG2N-2:0] j,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_addr
);

    logic [LOG2N-1:0] half;
    logic [LOG2N-2:0] pos_mask;
    logic [LOG2N-2:0] pos;
    logic [LOG2N-1:0] upper;
    logic [SW-1:0]    tw_shift;

    always_comb begin
        half = {{(LOG2N-1){1'b0}}, 1'b1} << s;

        // In the last stage 1<<s falls off the top of this narrower vector,
        // the shift yields zero and the decrement wraps to all ones, which is
        // exactly the mask 2^(LOG2N-1)-1 that stage needs.
        pos_mask = ({{(LOG2N-2){1'b0}}, 1'b1} << s) - 1'b1;
        pos      = j & pos_mask;

        // Bits of j at and above s move up by one to open a hole at bit s.
        upper    = (({1'b0, j} >> s) << 1) << s;
        addr_a   = upper | {1'b0, pos};
        addr_b   = addr_a | half;

        // pos < 2^s, so shifting by LOG2N-1-s never loses a set bit.
        tw_shift = SW'(LOG2N - 1) - s;
        tw_addr  = pos << tw_shift;
    end

endmodule

// File: rtl/fft_controller.sv
// ---------------------------------------------------------------------------
// fft_controller
// In-place radix-2 decimation-in-time FFT sequencer. After a start request it
// walks LOG2N stages of N_PTS/2 butterflies, one butterfly per cycle, issuing
// operand read addresses plus a twiddle index, and replays each read address
// RD_LAT cycles later as the write-back address. Between stages the sequencer
// idles for RD_LAT cycles (DRAIN) so the last writes of a stage land before
// the first reads of the next one.
// Ports:
//   i_CLK : clock, rising edge
//   i_RST : asynchronous active-high reset; aborts any transform in flight
//   bus   : fft_controller_if master modport (start, status, read/write
//           addresses, twiddle index, observed state)
// Parameters:
//   N_PTS  : transform length (power of two, 4..256)
//   LOG2N  : log2(N_PTS)
//   RD_LAT : cycles from a read strobe to the matching write strobe (>=1)
// ---------------------------------------------------------------------------
module fft_controller
    import fft_pkg::*;
#(
    parameter int N_PTS  = 16,
    parameter int LOG2N  = 4,
    parameter int RD_LAT = 1
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    fft_controller_if.master bus
);

    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int JW = LOG2N - 1;
    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [JW-1:0] J_LAST = JW'(N_PTS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [DW-1:0] D_LAST = DW'(RD_LAT - 1);

    fft_state_e       state;
    logic [SW-1:0]    s;
    logic [JW-1:0]    j;
    logic [DW-1:0]    drain_cnt;

    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG2N-1:0] rd_a;
    logic [LOG2N-1:0] rd_b;
    logic [JW-1:0]    tw;

    // Addresses are registered, so the generator is fed the (s, j) of the
    // butterfly that will be on the outputs in the next cycle.
    logic [SW-1:0]    gen_s;
    logic [JW-1:0]    gen_j;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [JW-1:0]    gen_tw;

    always_comb begin
        gen_s = s;
        gen_j = j + 1'b1;
        case (state)
            ST_IDLE: begin
                gen_s = '0;
                gen_j = '0;
            end
            ST_DRAIN: begin
                // Wraps past the last stage, but then the FSM goes to DONE
                // and the generated addresses are not used.
                gen_s = s + 1'b1;
                gen_j = '0;
            end
            default: ;
        endcase
    end

    fft_addr_gen #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_addr_gen (
        .s       (gen_s),
        .j       (gen_j),
        .addr_a  (gen_a),
        .addr_b  (gen_b),
        .tw_addr (gen_tw)
    );

    // -----------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state     <= ST_IDLE;
            s         <= '0;
            j         <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_a      <= '0;
            rd_b      <= '0;
            tw        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state <= ST_RUN;
                        s     <= '0;
                        j     <= '0;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                        rd_a  <= gen_a;
                        rd_b  <= gen_b;
                        tw    <= gen_tw;
                    end
                end

                ST_RUN: begin
                    if (j == J_LAST) begin
                        // Read and twiddle outputs rest at zero while no
                        // butterfly is being read.
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                        rd_en     <= 1'b0;
                        rd_a      <= '0;
                        rd_b      <= '0;
                        tw        <= '0;
                    end else begin
                        j    <= gen_j;
                        rd_a <= gen_a;
                        rd_b <= gen_b;
                        tw   <= gen_tw;
                    end
                end

                ST_DRAIN: begin
                    if (drain_cnt == D_LAST) begin
                        if (s == S_LAST) begin
                            // Last write happened in this DRAIN cycle.
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            s     <= gen_s;
                            j     <= '0;
                            rd_en <= 1'b1;
                            rd_a  <= gen_a;
                            rd_b  <= gen_b;
                            tw    <= gen_tw;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Write-back delay line: the read strobe and addresses, RD_LAT cycles
    // later. It runs freely, so the tail of each stage drains out during
    // the DRAIN state. Reset clears it so an aborted run writes nothing.
    // -----------------------------------------------------------------------
    logic [RD_LAT-1:0] wr_en_dl;
    logic [LOG2N-1:0]  wr_a_dl [RD_LAT];
    logic [LOG2N-1:0]  wr_b_dl [RD_LAT];

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            wr_en_dl <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                wr_a_dl[k] <= '0;
                wr_b_dl[k] <= '0;
            end
        end else begin
            wr_en_dl[0] <= rd_en;
            wr_a_dl[0]  <= rd_a;
            wr_b_dl[0]  <= rd_b;
            for (int k = 1; k < RD_LAT; k++) begin
                wr_en_dl[k] <= wr_en_dl[k-1];
                wr_a_dl[k]  <= wr_a_dl[k-1];
                wr_b_dl[k]  <= wr_b_dl[k-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output drive
    // -----------------------------------------------------------------------
    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
    assign bus.o_rd_en     = rd_en;
    assign bus.o_rd_addr_a = rd_a;
    assign bus.o_rd_addr_b = rd_b;
    assign bus.o_tw_addr   = tw;
    assign bus.o_wr_en     = wr_en_dl[RD_LAT-1];
    assign bus.o_wr_addr_a = wr_a_dl[RD_LAT-1];
    assign bus.o_wr_addr_b = wr_b_dl[RD_LAT-1];
    assign bus.o_state     = state;

endmodule

// File: tb/tb_fft_controller.sv
// ---------------------------------------------------------------------------
// tb_fft_controller
// Directed bench for fft_controller with N_PTS=16 at RD_LAT=1 (dut16) and
// RD_LAT=3 (dut3). Cycle k is the clock period after edge k-1; i_start is
// sampled at edge 0, so the first read is in cycle 1.
// ---------------------------------------------------------------------------
module tb_fft_controller;
    import fft_pkg::*;

    logic clk;
    logic rst;

    fft_controller_if #(.LOG2N(4)) b16 ();
    fft_controller_if #(.LOG2N(4)) b3 ();

    fft_controller #(.N_PTS(16), .LOG2N(4), .RD_LAT(1)) dut16 (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (b16)
    );

    fft_controller #(.N_PTS(16), .LOG2N(4), .RD_LAT(3)) dut3 (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (b3)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- capture storage ----------------
    localparam int NC = 100;
    logic       r_rd   [NC];
    logic [3:0] r_a    [NC];
    logic [3:0] r_b    [NC];
    logic [2:0] r_tw   [NC];
    logic       r_wr   [NC];
    logic [3:0] r_wa   [NC];
    logic [3:0] r_wb   [NC];
    logic       r_busy [NC];
    logic       r_done [NC];

    // twiddle ROM, Q1.15
    int tw_re [8];
    int tw_im [8];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) b16.i_start = v;
        else          b3.i_start  = v;
    endtask

    task automatic record(input int sel, input int c);
        if (sel == 0) begin
            r_rd[c] = b16.o_rd_en;   r_a[c] = b16.o_rd_addr_a; r_b[c] = b16.o_rd_addr_b;
            r_tw[c] = b16.o_tw_addr; r_wr[c] = b16.o_wr_en;    r_wa[c] = b16.o_wr_addr_a;
            r_wb[c] = b16.o_wr_addr_b; r_busy[c] = b16.o_busy; r_done[c] = b16.o_done;
        end else begin
            r_rd[c] = b3.o_rd_en;    r_a[c] = b3.o_rd_addr_a;  r_b[c] = b3.o_rd_addr_b;
            r_tw[c] = b3.o_tw_addr;  r_wr[c] = b3.o_wr_en;     r_wa[c] = b3.o_wr_addr_a;
            r_wb[c] = b3.o_wr_addr_b; r_busy[c] = b3.o_busy;   r_done[c] = b3.o_done;
        end
    endtask

    // Start high during cycle 0 and cycles 1..hold_until, and again during
    // restart_cyc; records cycles 1..NC-1.
    task automatic capture(input int sel, input int hold_until, input int restart_cyc);
        for (int c = 0; c < NC; c++) begin
            r_rd[c] = 0; r_a[c] = 0; r_b[c] = 0; r_tw[c] = 0; r_wr[c] = 0;
            r_wa[c] = 0; r_wb[c] = 0; r_busy[c] = 0; r_done[c] = 0;
        end
        set_start(sel, 1'b1);
        for (int c = 1; c < NC; c++) begin
            tick();
            record(sel, c);
            set_start(sel, (c <= hold_until) || (c == restart_cyc));
        end
        set_start(sel, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int wr_cnt;
        rst = 1'b1;
        b16.i_start = 1'b0;
        b3.i_start  = 1'b0;
        tick();
        tick();
        checks++;
        if ({b16.o_busy, b16.o_done, b16.o_rd_en, b16.o_rd_addr_a, b16.o_rd_addr_b, b16.o_tw_addr,
             b16.o_wr_en, b16.o_wr_addr_a, b16.o_wr_addr_b} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs_dut16: got nonzero outputs, expected all 0");
        end
        checks++;
        if (b16.o_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state_dut16: got %0d expected %0d", b16.o_state, ST_IDLE);
        end
        checks++;
        if ({b3.o_busy, b3.o_done, b3.o_rd_en, b3.o_wr_en} !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs_dut3: got nonzero outputs, expected all 0");
        end
        rst = 1'b0;
        tick();

        // Abort a run in cycle 10.
        b16.i_start = 1'b1;
        tick();
        b16.i_start = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        checks++;
        if (b16.o_rd_en !== 1'b1 || b16.o_rd_addr_a !== 4'd0 || b16.o_rd_addr_b !== 4'd2) begin
            errors++;
            $display("FAIL reset_prerun_cycle10: got rd_en=%0b a=%0d b=%0d expected 1 0 2",
                     b16.o_rd_en, b16.o_rd_addr_a, b16.o_rd_addr_b);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({b16.o_busy, b16.o_done, b16.o_rd_en, b16.o_rd_addr_a, b16.o_rd_addr_b, b16.o_tw_addr,
             b16.o_wr_en, b16.o_wr_addr_a, b16.o_wr_addr_b} !== 22'd0) begin
            errors++;
            $display("FAIL reset_midrun_outputs: got nonzero outputs, expected all 0");
        end
        tick();
        tick();
        rst = 1'b0;
        wr_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (b16.o_wr_en === 1'b1 || b16.o_rd_en === 1'b1) wr_cnt++;
        end
        checks++;
        if (wr_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_activity_after: got %0d active cycles expected 0", wr_cnt);
        end

        // A fresh start after release runs normally.
        capture(0, 0, 0);
        checks++;
        if (r_done[37] !== 1'b1 || r_rd[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_rerun: got done37=%0b rd1=%0b expected 1 1", r_done[37], r_rd[1]);
        end
    endtask

    task automatic test_stage0();
        capture(0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (r_rd[1+j] !== 1'b1 || r_a[1+j] !== 4'(2*j) || r_b[1+j] !== 4'(2*j+1) || r_tw[1+j] !== 3'd0) begin
                errors++;
                $display("FAIL stage0_j%0d: got rd=%0b a=%0d b=%0d tw=%0d expected 1 %0d %0d 0",
                         j, r_rd[1+j], r_a[1+j], r_b[1+j], r_tw[1+j], 2*j, 2*j+1);
            end
        end
        checks++;
        if (r_rd[9] !== 1'b0 || r_a[9] !== 4'd0 || r_b[9] !== 4'd0 || r_tw[9] !== 3'd0 || r_busy[9] !== 1'b1) begin
            errors++;
            $display("FAIL stage0_drain: got rd=%0b a=%0d b=%0d tw=%0d busy=%0b expected 0 0 0 0 1",
                     r_rd[9], r_a[9], r_b[9], r_tw[9], r_busy[9]);
        end
        checks++;
        if (r_rd[10] !== 1'b1 || r_a[10] !== 4'd0 || r_b[10] !== 4'd2) begin
            errors++;
            $display("FAIL stage1_first: got rd=%0b a=%0d b=%0d expected 1 0 2", r_rd[10], r_a[10], r_b[10]);
        end
    endtask

    task automatic test_stages_2_3();
        logic [3:0] s2_a [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11};
        logic [2:0] s2_tw [8] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd2, 3'd4, 3'd6};
        capture(0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (r_rd[19+j] !== 1'b1 || r_a[19+j] !== s2_a[j] || r_b[19+j] !== 4'(s2_a[j] + 4) || r_tw[19+j] !== s2_tw[j]) begin
                errors++;
                $display("FAIL stage2_j%0d: got a=%0d b=%0d tw=%0d expected %0d %0d %0d",
                         j, r_a[19+j], r_b[19+j], r_tw[19+j], s2_a[j], s2_a[j] + 4, s2_tw[j]);
            end
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (r_rd[28+j] !== 1'b1 || r_a[28+j] !== 4'(j) || r_b[28+j] !== 4'(j+8) || r_tw[28+j] !== 3'(j)) begin
                errors++;
                $display("FAIL stage3_j%0d: got a=%0d b=%0d tw=%0d expected %0d %0d %0d",
                         j, r_a[28+j], r_b[28+j], r_tw[28+j], j, j+8, j);
            end
        end
        // Stage 3 writes one cycle later, last one in the final DRAIN cycle.
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (r_wr[29+j] !== 1'b1 || r_wa[29+j] !== 4'(j) || r_wb[29+j] !== 4'(j+8)) begin
                errors++;
                $display("FAIL stage3_wr_j%0d: got wr=%0b wa=%0d wb=%0d expected 1 %0d %0d",
                         j, r_wr[29+j], r_wa[29+j], r_wb[29+j], j, j+8);
            end
        end
    endtask

    task automatic test_rd_lat3();
        int wr_cnt;
        capture(1, 0, 0);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (r_wr[4+j] !== 1'b1 || r_wa[4+j] !== 4'(2*j) || r_wb[4+j] !== 4'(2*j+1)) begin
                errors++;
                $display("FAIL lat3_stage0_wr_j%0d: got wr=%0b wa=%0d wb=%0d expected 1 %0d %0d",
                         j, r_wr[4+j], r_wa[4+j], r_wb[4+j], 2*j, 2*j+1);
            end
        end
        checks++;
        if (r_rd[9] !== 1'b0 || r_rd[10] !== 1'b0 || r_rd[11] !== 1'b0 || r_rd[12] !== 1'b1) begin
            errors++;
            $display("FAIL lat3_gap: got rd9..12=%0b%0b%0b%0b expected 0001", r_rd[9], r_rd[10], r_rd[11], r_rd[12]);
        end
        checks++;
        if (r_a[12] !== 4'd0 || r_b[12] !== 4'd2 || r_tw[12] !== 3'd0) begin
            errors++;
            $display("FAIL lat3_stage1_first: got a=%0d b=%0d tw=%0d expected 0 2 0", r_a[12], r_b[12], r_tw[12]);
        end
        checks++;
        if (r_wr[44] !== 1'b1 || r_wa[44] !== 4'd7 || r_wb[44] !== 4'd15 || r_rd[44] !== 1'b0) begin
            errors++;
            $display("FAIL lat3_last_write: got wr=%0b wa=%0d wb=%0d rd=%0b expected 1 7 15 0",
                     r_wr[44], r_wa[44], r_wb[44], r_rd[44]);
        end
        checks++;
        if (r_done[44] !== 1'b0 || r_done[45] !== 1'b1 || r_busy[45] !== 1'b0 || r_done[46] !== 1'b0) begin
            errors++;
            $display("FAIL lat3_done_cycle: got done44/45/46=%0b%0b%0b busy45=%0b expected 010 0",
                     r_done[44], r_done[45], r_done[46], r_busy[45]);
        end
        wr_cnt = 0;
        for (int c = 1; c < NC; c++) if (r_wr[c] === 1'b1) wr_cnt++;
        checks++;
        if (wr_cnt !== 32) begin
            errors++;
            $display("FAIL lat3_wr_total: got %0d expected 32", wr_cnt);
        end
    endtask

    task automatic test_handshake();
        int rd_cnt;
        int done_cnt;
        int busy_cnt;
        int wr_cnt;
        // Start held through the whole first run and its DONE cycle, dropped
        // for one IDLE cycle... no: raised again in cycle 38 to start run two.
        capture(0, 37, 38);
        rd_cnt = 0; done_cnt = 0; busy_cnt = 0; wr_cnt = 0;
        for (int c = 1; c <= 38; c++) begin
            if (r_rd[c] === 1'b1) rd_cnt++;
            if (r_done[c] === 1'b1) done_cnt++;
            if (r_busy[c] === 1'b1) busy_cnt++;
            if (r_wr[c] === 1'b1) wr_cnt++;
        end
        checks++;
        if (rd_cnt !== 32 || wr_cnt !== 32) begin
            errors++;
            $display("FAIL hs_single_run_counts: got rd=%0d wr=%0d expected 32 32", rd_cnt, wr_cnt);
        end
        checks++;
        if (done_cnt !== 1 || r_done[37] !== 1'b1 || r_busy[37] !== 1'b0) begin
            errors++;
            $display("FAIL hs_done_pulse: got count=%0d done37=%0b busy37=%0b expected 1 1 0",
                     done_cnt, r_done[37], r_busy[37]);
        end
        checks++;
        if (busy_cnt !== 36 || r_busy[1] !== 1'b1 || r_busy[36] !== 1'b1) begin
            errors++;
            $display("FAIL hs_busy_window: got cycles=%0d expected 36", busy_cnt);
        end
        checks++;
        if (r_rd[38] !== 1'b0 || r_rd[39] !== 1'b1 || r_busy[39] !== 1'b1 || r_a[39] !== 4'd0 || r_b[39] !== 4'd1) begin
            errors++;
            $display("FAIL hs_restart: got rd38=%0b rd39=%0b busy39=%0b a=%0d b=%0d expected 0 1 1 0 1",
                     r_rd[38], r_rd[39], r_busy[39], r_a[39], r_b[39]);
        end
        checks++;
        if (r_done[75] !== 1'b1 || r_done[74] !== 1'b0) begin
            errors++;
            $display("FAIL hs_second_done: got done74=%0b done75=%0b expected 0 1", r_done[74], r_done[75]);
        end
    endtask

    task automatic bfly(input logic [31:0] a, input logic [31:0] b, input int k,
                        output logic [31:0] oa, output logic [31:0] ob);
        int ar, ai, br, bi, tr, ti;
        cplx_t ca, cb;
        ca = a;
        cb = b;
        ar = int'(ca.re); ai = int'(ca.im);
        br = int'(cb.re); bi = int'(cb.im);
        tr = (br * tw_re[k] - bi * tw_im[k]) >>> 15;
        ti = (br * tw_im[k] + bi * tw_re[k]) >>> 15;
        oa = make_cplx(16'(ar + tr), 16'(ai + ti));
        ob = make_cplx(16'(ar - tr), 16'(ai - ti));
    endtask

    task automatic test_end_to_end();
        logic [31:0] ram [16];
        logic [31:0] pa, pb;
        logic        pv;
        logic        seen;
        int          re, im;
        for (int k = 0; k < 8; k++) begin
            tw_re[k] = int'(32767.0 * $cos(2.0 * 3.14159265358979 * k / 16.0));
            tw_im[k] = -int'(32767.0 * $sin(2.0 * 3.14159265358979 * k / 16.0));
        end
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        ram[0] = 32'h4000_0000;
        pa = '0; pb = '0; pv = 1'b0; seen = 1'b0;
        b16.i_start = 1'b1;
        tick();
        b16.i_start = 1'b0;
        for (int c = 1; c < 80 && !seen; c++) begin
            if (b16.o_wr_en === 1'b1 && pv) begin
                ram[b16.o_wr_addr_a] = pa;
                ram[b16.o_wr_addr_b] = pb;
            end
            if (b16.o_rd_en === 1'b1) begin
                bfly(ram[b16.o_rd_addr_a], ram[b16.o_rd_addr_b], int'(b16.o_tw_addr), pa, pb);
                pv = 1'b1;
            end else begin
                pv = 1'b0;
            end
            if (b16.o_done === 1'b1) seen = 1'b1;
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL e2e_done_seen: got no o_done within 80 cycles expected one");
        end
        for (int i = 0; i < 16; i++) begin
            re = int'($signed(ram[i][31:16]));
            im = int'($signed(ram[i][15:0]));
            checks++;
            if (re < 16383 || re > 16385 || im < -1 || im > 1) begin
                errors++;
                $display("FAIL e2e_word%0d: got 0x%08h expected 0x40000000 +-1", i, ram[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        b16.i_start = 1'b0;
        b3.i_start  = 1'b0;
        test_reset();
        test_stage0();
        test_stages_2_3();
        test_rd_lat3();
        test_handshake();
        test_end_to_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_controller.md
# fft_controller

In-place radix-2 decimation-in-time FFT sequencer that drives the `butterfly_sum` datapath. After a start pulse it walks all `LOG2N` stages and `N_PTS/2` butterflies per stage. For each butterfly it issues operand read addresses to the sample RAM and a twiddle ROM index, then issues delayed write-back addresses once the butterfly result is valid. Samples are stored in bit-reversed order before start; results are in natural order at done.

## Interface
Parameters:
- `N_PTS`, 16, transform length; power of two, 4..256
- `LOG2N`, 4, log2(`N_PTS`)
- `RD_LAT`, 1, cycles from `o_rd_en` to valid butterfly output at the RAM write port; must be ≥1

Ports:
- `i_CLK`  in  1  clock; all logic on the rising edge
- `i_RST`  in  1  reset, asynchronous, active-high
- `i_start`  in  1  starts a transform when sampled high in IDLE
- `o_busy`  out  1  high from the first read cycle through the last write cycle
- `o_done`  out  1  one-cycle pulse after the last write
- `o_rd_en`  out  1  operand read strobe
- `o_rd_addr_a`, `o_rd_addr_b`  out  `LOG2N`  butterfly A and B sample addresses
- `o_tw_addr`  out  `LOG2N-1`  twiddle index k, meaning W = e^(-j2πk/N_PTS)
- `o_wr_en`  out  1  result write strobe; writes A to `o_wr_addr_a` and B to `o_wr_addr_b` in the same cycle
- `o_wr_addr_a`, `o_wr_addr_b`  out  `LOG2N`  write-back addresses

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `i_start`=1 → RUN with s=0, j=0.
  - `i_start` is ignored in every state except IDLE.
- **RUN:** one butterfly per cycle with `o_rd_en`=1.
  - j increments each cycle.
  - At j=`N_PTS`/2-1 → DRAIN.
- **DRAIN:**
  - Lasts exactly `RD_LAT` cycles with `o_rd_en`=0.
  - Then → RUN with s+1 and j=0, or → DONE if s=`LOG2N`-1.
  - Purpose: prevents read-after-write hazards across stages on the in-place RAM.
- **DONE:** one cycle with `o_done`=1 and `o_busy`=0, then → IDLE.
- **Address generation for stage s, butterfly j:**
  - half = 1<<s; pos = j & (half-1).
  - `o_rd_addr_a` = j with a 0 inserted at bit s, i.e. ((j>>s)<<(s+1)) | pos.
  - `o_rd_addr_b` = `o_rd_addr_a` | half.
  - `o_tw_addr` = pos << (`LOG2N`-1-s), truncated to `LOG2N`-1 bits.
- **Write-back:**
  - `o_wr_en`, `o_wr_addr_a` and `o_wr_addr_b` are `o_rd_en`, `o_rd_addr_a` and `o_rd_addr_b` delayed by exactly `RD_LAT` cycles through a shift register.
  - The delay line keeps running through DRAIN, so the final writes of each stage appear during DRAIN.
- **Outputs when `o_rd_en`=0:** the read and twiddle address outputs are 0.
- **Reset:**
  - Every output is 0, the state is IDLE, and the delay line is cleared.
  - Reset asserted mid-transform aborts immediately. No further `o_wr_en` is issued and RAM contents are undefined.

## Timing
- `i_start` is sampled at edge 0.
- First `o_rd_en` and `o_busy` occur in cycle 1.
- Each stage occupies `N_PTS`/2 + `RD_LAT` cycles.
- `o_done` is in cycle 1 + `LOG2N`·(`N_PTS`/2 + `RD_LAT`). Defaults: cycle 37.
- `o_wr_en` is high for exactly `LOG2N`·`N_PTS`/2 cycles in total. Defaults: 32.
- The last write of stage s occurs no later than the cycle before the first read of stage s+1.
- A new `i_start` is accepted in the IDLE cycle immediately following DONE.

## Structure
- **Package `fft_pkg`:**
  - state enum
  - `WORD_SZ`=32, `WORD_MID`=16
  - complex word layout: real in [31:16], imaginary in [15:0], two's complement
- **Sub-module `fft_addr_gen`:** combinational; inputs (s, j); outputs addr_a, addr_b, tw_addr. Unit-testable on its own.
- **Controller body:** FSM, counters s and j, and the `RD_LAT`-deep delay line.

## Test plan
- **Reset:** assert `i_RST` at cycle 10 of a run → all outputs 0 in the same cycle, no `o_wr_en` afterwards, and a new `i_start` after release runs normally.
- **Stage 0 (defaults):**
  - read pairs (0,1),(2,3),…,(14,15)
  - `o_tw_addr` = 0 throughout
  - one DRAIN cycle with `o_rd_en`=0
- **Stages 2 and 3:**
  - stage 2 pairs (0,4),(1,5),(2,6),(3,7),(8,12),…; tw = 0,2,4,6,0,2,4,6
  - stage 3 pairs (0,8)…(7,15); tw = 0…7
- **`RD_LAT`=3:**
  - write addresses equal read addresses delayed by 3 cycles
  - 3-cycle gaps between stages
  - `o_done` at cycle 1+4·11=45
- **Handshake:**
  - `i_start` held high for the whole run → exactly one transform
  - `o_done` high for one cycle with `o_busy`=0
  - `i_start` in the next cycle starts a second run
- **End-to-end:** controller + RAM model + `butterfly_sum` + Q1.15 twiddle ROM; impulse 0x4000_0000 at address 0 → every output word equals 0x4000_0000 (±1 LSB) after `o_done`.
